// File: rtl/rf_param_clr.sv
// Parametrised NRD-read / 1-write register file with optional hardwired-zero entry 0
// and a sequential clear engine. Define RF_BYPASS_EN for write-through read forwarding.
module rf_param_clr #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 64,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 CLR,
  output logic                 BUSY,
  input  logic                 WR,
  input  logic [AW-1:0]        RW,
  input  logic [WIDTH-1:0]     DW,
  input  logic [NRD*AW-1:0]    RA,
  output logic [NRD*WIDTH-1:0] DR
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (CLR) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // BUSY comes straight from the state flop, so it is registered.
  assign BUSY  = (state == CLEAR);
  assign wr_en = !HRESET && (state == IDLE) && WR && !(ZERO_REG && (RW == '0));

  // NOTE: the array has no reset branch; it is zeroed only by the clear engine.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (wr_en)
        mem[RW] <= DW;
    end
  end

  // Zero-forcing (busy, entry 0) takes priority over both storage and forwarding.
  always_comb begin
    DR = '0;
    for (int p = 0; p < NRD; p++) begin
      if (!BUSY && !(ZERO_REG && (RA[p*AW +: AW] == '0))) begin
        DR[p*WIDTH +: WIDTH] = mem[RA[p*AW +: AW]];
`ifdef RF_BYPASS_EN
        if (wr_en && (RA[p*AW +: AW] == RW)) DR[p*WIDTH +: WIDTH] = DW;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rf_param_clr.sv
// Directed bench for rf_param_clr: reset clear, reads/writes, zero entry,
// read-during-write (both builds), CLR while busy and reset mid-clear.
module tb_rf_param_clr;

  localparam int W   = 64;
  localparam int D   = 64;
  localparam int A   = 6;
  localparam int NRD = 3;

  logic             HCLK;
  logic             HRESET;
  logic             CLR;
  logic             WR;
  logic [A-1:0]     RW;
  logic [W-1:0]     DW;
  logic [NRD*A-1:0] RA;
  logic             busy_z, busy_n;
  logic [NRD*W-1:0] dr_z, dr_n;

  int checks = 0;
  int errors = 0;

  rf_param_clr #(.WIDTH(W), .DEPTH(D), .NRD(NRD), .ZERO_REG(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .CLR(CLR), .BUSY(busy_z), .WR(WR),
    .RW(RW), .DW(DW), .RA(RA), .DR(dr_z)
  );

  rf_param_clr #(.WIDTH(W), .DEPTH(D), .NRD(NRD), .ZERO_REG(1'b0)) dut_nz (
    .HCLK(HCLK), .HRESET(HRESET), .CLR(CLR), .BUSY(busy_n), .WR(WR),
    .RW(RW), .DW(DW), .RA(RA), .DR(dr_n)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [W-1:0] port(input logic [NRD*W-1:0] v, input int p);
    return v[p*W +: W];
  endfunction

  task automatic set_ra(input int a0, input int a1, input int a2);
    RA = {A'(a2), A'(a1), A'(a0)};
  endtask

  task automatic write(input int addr, input logic [W-1:0] data);
    WR = 1'b1; RW = A'(addr); DW = data;
    tick();
    WR = 1'b0;
  endtask

  // Counts edges until BUSY falls; expects exactly D.
  task automatic wait_clear(input string name);
    int n = 0;
    while (busy_z === 1'b1 && n < 4 * D) begin
      tick();
      n++;
    end
    checks++;
    if (n !== D || busy_n !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy cycles %0d busy_nz %b, expected %0d and 0", name, n, busy_n, D);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < D; a += NRD) begin
      set_ra(a, (a + 1) % D, (a + 2) % D);
      #1;
      checks++;
      if (dr_z !== '0 || dr_n !== '0) begin
        errors++;
        $display("FAIL %s: addr %0d.. dr=%h dr_nz=%h expected 0", name, a, dr_z, dr_n);
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    for (int i = 0; i < D; i++) begin
      set_ra(i, (i * 7) % D, D - 1 - i);
      #1;
      checks++;
      if (busy_z !== 1'b1 || dr_z !== '0 || dr_n !== '0) begin
        errors++;
        $display("FAIL reset_busy: cycle %0d busy=%b dr=%h dr_nz=%h expected busy=1 dr=0",
                 i, busy_z, dr_z, dr_n);
      end
      tick();
    end
    checks++;
    if (busy_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_fall: busy=%b expected 0", busy_z);
    end
    check_all_zero("reset_contents");
  endtask

  task automatic test_write_read();
    write(5, 64'hDEADBEEF_CAFEF00D);
    write(63, 64'h1);
    set_ra(5, 63, 5);
    #1;
    checks++;
    if (dr_z !== {64'hDEADBEEF_CAFEF00D, 64'h1, 64'hDEADBEEF_CAFEF00D}) begin
      errors++;
      $display("FAIL write_read: dr=%h expected %h", dr_z,
               {64'hDEADBEEF_CAFEF00D, 64'h1, 64'hDEADBEEF_CAFEF00D});
    end
  endtask

  task automatic test_zero_reg();
    write(0, '1);
    set_ra(0, 0, 5);
    #1;
    checks++;
    if (port(dr_z, 0) !== '0 || port(dr_z, 1) !== '0 || port(dr_z, 2) !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL zero_reg_on: dr=%h expected 0,0,deadbeef_cafef00d", dr_z);
    end
    checks++;
    if (port(dr_n, 0) !== {W{1'b1}} || port(dr_n, 1) !== {W{1'b1}}) begin
      errors++;
      $display("FAIL zero_reg_off: dr_nz=%h expected all ones on ports 0,1", dr_n);
    end
  endtask

  task automatic test_rdw();
    logic [W-1:0] exp_same;
`ifdef RF_BYPASS_EN
    exp_same = 64'hBB;
`else
    exp_same = 64'hAA;
`endif
    write(7, 64'hAA);
    WR = 1'b1; RW = 7; DW = 64'hBB;
    set_ra(7, 6, 0);
    #1;
    checks++;
    if (port(dr_z, 0) !== exp_same || port(dr_n, 0) !== exp_same) begin
      errors++;
      $display("FAIL rdw_same_cycle: dr=%h dr_nz=%h expected %h", port(dr_z, 0), port(dr_n, 0), exp_same);
    end
    tick();
    WR = 1'b0;
    checks++;
    if (port(dr_z, 0) !== 64'hBB) begin
      errors++;
      $display("FAIL rdw_next_cycle: dr=%h expected bb", port(dr_z, 0));
    end
    // Entry 0 is never forwarded when hardwired to zero.
    WR = 1'b1; RW = 0; DW = 64'h1234;
    set_ra(0, 7, 7);
    #1;
    checks++;
    if (port(dr_z, 0) !== '0 || port(dr_z, 1) !== 64'hBB) begin
      errors++;
      $display("FAIL rdw_zero_fwd: dr=%h expected port0=0 port1=bb", dr_z);
    end
    tick();
    WR = 1'b0;
  endtask

  task automatic test_clr_busy();
    int n = 0;
    for (int i = 1; i <= 10; i++) write(i, 64'(100 + i));
    set_ra(3, 10, 1);
    #1;
    checks++;
    if (dr_z !== {64'd101, 64'd110, 64'd103}) begin
      errors++;
      $display("FAIL fill: dr=%h expected 65,6e,67 (hex) on ports 2,1,0", dr_z);
    end
    // Write and CLR in the same idle cycle: write lands, then clear wipes it.
    CLR = 1'b1; WR = 1'b1; RW = 11; DW = 64'h77;
    tick();
    CLR = 1'b0; WR = 1'b0;
    checks++;
    if (busy_z !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_rise: busy=%b expected 1", busy_z);
    end
    while (busy_z === 1'b1 && n < 4 * D) begin
      WR  = (n == 20);
      RW  = 3;
      DW  = 64'h55;
      CLR = (n == 10 || n == 40);
      tick();
      n++;
    end
    WR = 1'b0; CLR = 1'b0;
    checks++;
    if (n !== D) begin
      errors++;
      $display("FAIL clr_length: busy cycles %0d expected %0d", n, D);
    end
    check_all_zero("clr_contents");
  endtask

  task automatic test_reset_mid_clear();
    write(40, 64'h1234);
    write(9, 64'h99);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    repeat (20) tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    wait_clear("reset_mid_clear_length");
    check_all_zero("reset_mid_clear_contents");
  endtask

  initial begin
    HRESET = 1'b0; CLR = 1'b0; WR = 1'b0; RW = '0; DW = '0; RA = '0;
    tick();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_rdw();
    test_clr_busy();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_param_clr.md
Name: rf_param_clr

Overview:
- Parametrised multi-read-port, single-write-port register file.
- Successor to the fixed 64x64 two-read register file.
- Generalises width, depth and read-port count; keeps the hardwired-zero entry 0 as an option.
- Adds a sequential clear engine: after reset, or on request, it zeroes every entry one per cycle and reports busy. Sits in the CPU datapath between decode and execute.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 64, number of entries; power of two, 2..1024.
- AW, $clog2(DEPTH), address width (derived; do not override).
- NRD, 2, number of read ports, 1..8.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary entry.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESET  input  1  reset; synchronous, active-high.
- CLR  input  1  request a full clear; sampled when not busy.
- BUSY  output  1  high while the clear engine runs.
- WR  input  1  write enable.
- RW  input  AW  write address.
- DW  input  WIDTH  write data.
- RA  input  NRD*AW  read addresses; port p at bits [p*AW +: AW].
- DR  output  NRD*WIDTH  read data; port p at bits [p*WIDTH +: WIDTH].

Behaviour:
- Storage: DEPTH x WIDTH register array. Entries hold no reset value except through the clear engine.
- FSM has two states, IDLE and CLEAR; encoding is free.
- HRESET high at an edge:
  - state <= CLEAR, clear counter <= 0, BUSY <= 1 on the next cycle.
  - HRESET overrides everything, including a clear already in progress, which restarts from 0.
- CLEAR state:
  - Each cycle writes 0 to entry[counter], then counter increments.
  - When counter == DEPTH-1 is written, go to IDLE; BUSY drops the following cycle.
  - The clear takes exactly DEPTH cycles after HRESET is released.
  - If ZERO_REG=1, entry 0 is still written (harmless); the cycle count is unchanged.
- BUSY is registered: 1 in CLEAR, 0 in IDLE. BUSY = 1 during and immediately after reset.
- IDLE state:
  - CLR=1 moves to CLEAR with counter = 0; the clear starts on the next cycle.
  - CLR is ignored while BUSY=1; it is not queued.
- Writes:
  - In IDLE with WR=1, entry[RW] <= DW at the edge.
  - If ZERO_REG=1 and RW==0, the write is dropped.
  - A write with WR=1 and CLR=1 in the same IDLE cycle is performed, then the clear begins; the clear wins in the end.
  - Writes while BUSY=1 are dropped silently.
- Reads:
  - Combinational. Each port p: DR[p] = entry[RA[p]].
  - Forced to 0 when ZERO_REG=1 and RA[p]==0.
  - Forced to 0 on all ports while BUSY=1, so partially cleared contents are never visible.
  - Ports are independent; any port may alias any other address.
- Read-during-write (no bypass): a read of RW in the write cycle returns the old value; the new value is visible from the next cycle.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - In IDLE with WR=1, any read port with RA[p]==RW returns DW in the same cycle (write-through forwarding).
  - The ZERO_REG zero-forcing and BUSY zero-forcing still take priority; RW==0 with ZERO_REG=1 is never forwarded.
- Not defined: reads return the stored value only (old-value semantics above). No bypass logic is synthesised.

Test Plan:
- Reset clear: WIDTH=64, DEPTH=64, pulse HRESET 1 cycle.
  - BUSY=1 for exactly 64 cycles after release, DR all 0 throughout.
  - After BUSY falls, reading every address returns 0.
- Write/read, 3 ports (NRD=3), after clear:
  - Write 0xDEADBEEF_CAFEF00D to entry 5 and 0x1 to entry 63.
  - Next cycle, RA={5,63,5} gives DR={0xDEADBEEF_CAFEF00D, 0x1, 0xDEADBEEF_CAFEF00D}.
- Zero register: ZERO_REG=1, write 0xFFFF... to RW=0; RA=0 returns 0.
  - With ZERO_REG=0, the same sequence returns 0xFFFF....
- Read-during-write: entry 7 holds 0xAA, write 0xBB to 7 with RA=7.
  - Same cycle, DR=0xAA without RF_BYPASS_EN, 0xBB with it.
  - Next cycle, 0xBB in both builds.
- CLR and writes while busy:
  - Fill entries 1..10, assert CLR; BUSY rises next cycle.
  - WR to entry 3 with 0x55 during the clear is dropped.
  - After BUSY falls, entries 1..10 read 0.
  - A CLR pulse during BUSY does not extend the clear beyond DEPTH cycles.
- Reset mid-clear: assert CLR, wait 20 cycles, pulse HRESET.
  - Counter restarts; BUSY stays high for DEPTH cycles after HRESET release; all entries end at 0.
